// File: rtl/div_rep_sub_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LDB  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_rep_sub_if.sv
// Operand/result bundle for the divider; the requester drives start/data_in.
interface div_rep_sub_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div0;

  modport master (
    output start, data_in,
    input  quotient, remainder, done, busy, div0
  );

  modport slave (
    input  start, data_in,
    output quotient, remainder, done, busy, div0
  );
endinterface : div_rep_sub_if

// File: rtl/div_rep_sub_ctrl.sv
// Control FSM for the divider: sequences operand loads and the subtract loop.
module div_rep_sub_ctrl
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic b_zero_i,
  input  logic a_ge_b_i,
  output logic ld_a_o,
  output logic ld_b_o,
  output logic clr_q_o,
  output logic sub_en_o,
  output logic set_div0_o,
  output logic done_o,
  output logic busy_o
);

  div_state_e state_q, state_d;
  logic       done_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d == LDB) || (state_d == SUB);
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_a_o     = 1'b0;
    ld_b_o     = 1'b0;
    clr_q_o    = 1'b0;
    sub_en_o   = 1'b0;
    set_div0_o = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start directly so operations can run back-to-back
        if (start_i) begin
          ld_a_o  = 1'b1;
          clr_q_o = 1'b1;
          state_d = LDB;
        end else begin
          state_d = IDLE;
        end
      end
      LDB: begin
        ld_b_o  = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        if (b_zero_i) begin
          set_div0_o = 1'b1;
          state_d    = DONE;
        end else if (a_ge_b_i) begin
          sub_en_o = 1'b1;
          state_d  = SUB;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule : div_rep_sub_ctrl

// File: rtl/div_rep_sub.sv
// Unsigned divider by repeated subtraction: A = running remainder, B = divisor, Q = quotient.
module div_rep_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  div_rep_sub_if.slave bus
);

  logic [WIDTH-1:0] a_q, b_q, q_q;
  logic             div0_q;
  logic             ld_a_s, ld_b_s, clr_q_s, sub_en_s, set_div0_s;
  logic             b_zero_s, a_ge_b_s;

  assign b_zero_s = (b_q == {WIDTH{1'b0}});
  assign a_ge_b_s = (a_q >= b_q);

  div_rep_sub_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (bus.start),
    .b_zero_i   (b_zero_s),
    .a_ge_b_i   (a_ge_b_s),
    .ld_a_o     (ld_a_s),
    .ld_b_o     (ld_b_s),
    .clr_q_o    (clr_q_s),
    .sub_en_o   (sub_en_s),
    .set_div0_o (set_div0_s),
    .done_o     (bus.done),
    .busy_o     (bus.busy)
  );

  // sub_en is only raised when A >= B, so the subtraction cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= {WIDTH{1'b0}};
      b_q    <= {WIDTH{1'b0}};
      q_q    <= {WIDTH{1'b0}};
      div0_q <= 1'b0;
    end else begin
      if (ld_a_s) begin
        a_q <= bus.data_in;
      end else if (sub_en_s) begin
        a_q <= a_q - b_q;
      end else begin
        a_q <= a_q;
      end

      if (ld_b_s) begin
        b_q <= bus.data_in;
      end else begin
        b_q <= b_q;
      end

      if (clr_q_s) begin
        q_q <= {WIDTH{1'b0}};
      end else if (set_div0_s) begin
        q_q <= {WIDTH{1'b1}};
      end else if (sub_en_s) begin
        q_q <= q_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        q_q <= q_q;
      end

      if (ld_a_s) begin
        div0_q <= 1'b0;
      end else if (set_div0_s) begin
        div0_q <= 1'b1;
      end else begin
        div0_q <= div0_q;
      end
    end
  end

  assign bus.quotient  = q_q;
  assign bus.remainder = a_q;
  assign bus.div0      = div0_q;

endmodule : div_rep_sub

// File: tb/tb_div_rep_sub.sv
// Directed self-checking bench for div_rep_sub.
module tb_div_rep_sub;
  import div_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   busy_cnt;
  int   edges;

  div_rep_sub_if #(.WIDTH(16)) bus ();

  div_rep_sub #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives dividend on E0 and divisor on E1; returns 1 ns after E1.
  task automatic issue(input logic [15:0] dvd, input logic [15:0] dvs);
    bus.start   = 1'b1;
    bus.data_in = dvd;
    @(posedge clk); #1;
    busy_cnt    = bus.busy ? 1 : 0;
    bus.start   = 1'b0;
    bus.data_in = dvs;
    @(posedge clk); #1;
    if (bus.busy) busy_cnt++;
    bus.data_in = 16'hDEAD;
  endtask

  // Counts edges after E(e0) until done is seen 1 ns after an edge.
  task automatic wait_done(input int e0, output int e_done);
    int n;
    n = e0;
    e_done = -1;
    for (int k = 0; k < 70000; k++) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) begin
        e_done = n;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    if (e_done < 0) begin
      checks++;
      failures++;
      $error("FAIL timeout waiting for done");
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = 16'h0000;
    #12;
    chk("rst_quot", 32'(bus.quotient), 32'h0);
    chk("rst_rem",  32'(bus.remainder), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_div0", 32'(bus.div0), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 17 / 5
    issue(16'd17, 16'd5);
    wait_done(1, edges);
    chk("17_5_edge", 32'(edges), 32'd5);
    chk("17_5_quot", 32'(bus.quotient), 32'd3);
    chk("17_5_rem",  32'(bus.remainder), 32'd2);
    chk("17_5_div0", 32'(bus.div0), 32'd0);
    chk("17_5_busy", 32'(busy_cnt), 32'd5);
    @(posedge clk); #1;
    chk("17_5_pulse", 32'(bus.done), 32'd0);
    chk("17_5_hold", 32'(bus.quotient), 32'd3);

    // 5 / 17
    issue(16'd5, 16'd17);
    wait_done(1, edges);
    chk("5_17_edge", 32'(edges), 32'd2);
    chk("5_17_quot", 32'(bus.quotient), 32'd0);
    chk("5_17_rem",  32'(bus.remainder), 32'd5);

    // divide by zero
    @(posedge clk); #1;
    issue(16'h1234, 16'h0000);
    wait_done(1, edges);
    chk("d0_edge", 32'(edges), 32'd2);
    chk("d0_flag", 32'(bus.div0), 32'd1);
    chk("d0_quot", 32'(bus.quotient), 32'hFFFF);
    chk("d0_rem",  32'(bus.remainder), 32'h1234);
    @(posedge clk); #1;
    chk("d0_hold", 32'(bus.div0), 32'd1);

    // worst case 0xFFFF / 1
    issue(16'hFFFF, 16'h0001);
    chk("wc_div0_clr", 32'(bus.div0), 32'd0);
    wait_done(1, edges);
    chk("wc_edge", 32'(edges), 32'd65537);
    chk("wc_quot", 32'(bus.quotient), 32'hFFFF);
    chk("wc_rem",  32'(bus.remainder), 32'h0);

    // start during SUB is ignored, then back-to-back on the done cycle
    @(posedge clk); #1;
    issue(16'd100, 16'd7);
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.data_in = 16'd99;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    wait_done(3, edges);
    chk("100_7_edge", 32'(edges), 32'd16);
    chk("100_7_quot", 32'(bus.quotient), 32'd14);
    chk("100_7_rem",  32'(bus.remainder), 32'd2);
    issue(16'd20, 16'd4);
    wait_done(1, edges);
    chk("b2b_edge", 32'(edges), 32'd7);
    chk("b2b_quot", 32'(bus.quotient), 32'd5);
    chk("b2b_rem",  32'(bus.remainder), 32'd0);

    // asynchronous reset mid-SUB
    @(posedge clk); #1;
    issue(16'd1000, 16'd3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_quot",  32'(bus.quotient), 32'h0);
    chk("mr_rem",   32'(bus.remainder), 32'h0);
    chk("mr_busy",  32'(bus.busy), 32'h0);
    chk("mr_done",  32'(bus.done), 32'h0);
    chk("mr_div0",  32'(bus.div0), 32'h0);
    chk("mr_state", 32'(dut.u_ctrl.state_q), 32'(IDLE));
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    issue(16'd9, 16'd2);
    wait_done(1, edges);
    chk("9_2_edge", 32'(edges), 32'd6);
    chk("9_2_quot", 32'(bus.quotient), 32'd4);
    chk("9_2_rem",  32'(bus.remainder), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div_rep_sub
